// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants: transmitter/receiver state encodings,
//                oversampling ratio and stop-period tick counts.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // FSM state encodings, shared with the receiver
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // Baud tick is 16x the bit rate
    localparam int OVERSAMPLE = 16;

    // Stop-period lengths in s_ticks
    localparam int SB_1   = 16;
    localparam int SB_1P5 = 24;
    localparam int SB_2   = 32;

endpackage
`default_nettype wire

// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_framer
//  Description : UART transmitter. Serialises one DBIT-wide word per request
//                into start / data (LSB first) / optional parity / stop bits,
//                timed by a 16x oversampling baud tick.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = SB_1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    // Terminal counts, sized to the counters they are compared with
    localparam logic [4:0] BIT_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST    = 3'(DBIT - 1);
    localparam logic       PAR_SEED  = (PARITY_ODD != 0);
    localparam logic       HAS_PAR   = (PARITY_EN != 0);

    logic [2:0]      state_q, state_d;
    logic [4:0]      s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            done;

    // State, counters, shift register and line register; reset parks the line high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state, counter and done-pulse logic
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        par_d   = par_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                // Accept on this edge; the start bit is not tick-aligned
                if (tx_start) begin
                    b_d     = din;
                    par_d   = (^din) ^ PAR_SEED;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == N_LAST) begin
                            state_d = HAS_PAR ? PARITY : STOP;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == STOP_LAST) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Line value for the state being entered, so the pin comes straight off a flop
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != IDLE);
    assign tx_done_tick = done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_framer
//  Description : Self-checking bench for uart_tx_framer. Four instances cover
//                the default frame, even and odd parity, and a 2-stop-bit
//                period. Expected line bits are queued when a frame is
//                requested and compared mid-bit as the line is observed.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_framer;

    localparam int ND = 4;

    // Per-instance configuration, mirrored for the reference model
    localparam int CFG_PE   [ND] = '{0, 1, 1, 0};
    localparam int CFG_ODD  [ND] = '{0, 0, 1, 0};
    localparam int CFG_SB   [ND] = '{16, 16, 16, 32};

    typedef struct {
        int   d;
        logic b;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          s_tick;
    logic [ND-1:0] tx_start;
    logic [7:0]    din [ND];
    logic [ND-1:0] tx_w;
    logic [ND-1:0] busy_w;
    logic [ND-1:0] done_w;

    int   n_cmp;
    int   n_err;
    int   tick_div;
    exp_t exp_q [$];

    // Reference model state per instance
    logic m_active [ND];
    int   m_ticks  [ND];
    int   m_len    [ND];
    logic m_was;
    logic m_exp_done;
    exp_t m_e;

    uart_tx_framer u_dut0 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[0]), .din(din[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0])
    );
    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[1]), .din(din[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1])
    );
    uart_tx_framer #(.PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[2]), .din(din[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2])
    );
    uart_tx_framer #(.SB_TICK(32)) u_dut3 (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start[3]), .din(din[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Baud tick: one pulse every tick_div clocks; tick_div = 1 holds it high
    initial begin
        int cnt;
        cnt    = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= tick_div) begin
                cnt    = 0;
                s_tick = 1'b1;
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // Queue the expected line bits of one frame (one entry per 16-tick slot)
    task automatic push_frame(input int d, input logic [7:0] data);
        exp_t e;
        e.d = d;
        e.b = 1'b0;
        exp_q.push_back(e);
        for (int i = 0; i < 8; i++) begin
            e.b = data[i];
            exp_q.push_back(e);
        end
        if (CFG_PE[d] != 0) begin
            e.b = (^data) ^ (CFG_ODD[d] != 0);
            exp_q.push_back(e);
        end
        for (int i = 0; i < CFG_SB[d] / 16; i++) begin
            e.b = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    // Reference model and monitor, evaluated away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            for (int d = 0; d < ND; d++) begin
                m_active[d] = 1'b0;
                m_ticks[d]  = 0;
            end
            exp_q.delete();
        end else begin
            for (int d = 0; d < ND; d++) begin
                m_was      = m_active[d];
                m_exp_done = 1'b0;
                chk($sformatf("busy%0d", d), {31'd0, busy_w[d]}, {31'd0, m_was});
                if (!m_was)
                    chk($sformatf("idle_tx%0d", d), {31'd0, tx_w[d]}, 32'd1);
                if (m_was && s_tick) begin
                    m_ticks[d]++;
                    if (m_ticks[d] % 16 == 8) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("unexpected_bit%0d", d), 32'd1, 32'd0);
                        end else begin
                            m_e = exp_q.pop_front();
                            chk("bit_owner", d, m_e.d);
                            chk($sformatf("bit%0d_slot%0d", d, m_ticks[d] / 16),
                                {31'd0, tx_w[d]}, {31'd0, m_e.b});
                        end
                    end
                    if (m_ticks[d] == m_len[d]) begin
                        m_exp_done  = 1'b1;
                        m_active[d] = 1'b0;
                    end
                end
                chk($sformatf("done%0d", d), {31'd0, done_w[d]}, {31'd0, m_exp_done});
                if (!m_was && tx_start[d]) begin
                    m_active[d] = 1'b1;
                    m_ticks[d]  = 0;
                end
            end
        end
    end

    task automatic wait_idle(input int d);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (!m_active[d]) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("idle_timeout%0d", d), {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_ticks(input int d, input int t);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (m_ticks[d] >= t) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("tick_timeout%0d", d), {31'd0, ok}, 32'd1);
    endtask

    task automatic send(input int d, input logic [7:0] data);
        push_frame(d, data);
        @(posedge clk);
        #1;
        din[d]      = data;
        tx_start[d] = 1'b1;
        @(posedge clk);
        #1;
        tx_start[d] = 1'b0;
    endtask

    initial begin
        logic ok;
        n_cmp    = 0;
        n_err    = 0;
        tick_div = 3;
        reset    = 1'b1;
        tx_start = '0;
        for (int d = 0; d < ND; d++) begin
            din[d]      = 8'h00;
            m_active[d] = 1'b0;
            m_ticks[d]  = 0;
            m_len[d]    = 16 * (9 + CFG_PE[d]) + CFG_SB[d];
        end

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("rst_tx%0d", d), {31'd0, tx_w[d]}, 32'd1);
            chk($sformatf("rst_busy%0d", d), {31'd0, busy_w[d]}, 32'd0);
            chk($sformatf("rst_done%0d", d), {31'd0, done_w[d]}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle line after reset with ticks running
        repeat (1000) @(posedge clk);

        // Default frame, then a continuous-tick frame
        send(0, 8'hA5);
        wait_idle(0);
        tick_div = 1;
        send(0, 8'h3C);
        wait_idle(0);

        // Even and odd parity
        tick_div = 2;
        send(1, 8'h07);
        wait_idle(1);
        send(2, 8'h07);
        wait_idle(2);

        // Request and din change during DATA are ignored
        send(0, 8'h96);
        wait_ticks(0, 40);
        @(posedge clk);
        #1;
        din[0]      = 8'hFF;
        tx_start[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_start[0] = 1'b0;
        din[0]      = 8'h00;
        wait_idle(0);

        // tx_start held across two frames on the 2-stop-bit instance
        tick_div = 1;
        push_frame(3, 8'h3C);
        push_frame(3, 8'h55);
        @(posedge clk);
        #1;
        din[3]      = 8'h3C;
        tx_start[3] = 1'b1;
        ok          = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (done_w[3]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("first_done3", {31'd0, ok}, 32'd1);
        din[3] = 8'h55;
        @(posedge clk);
        @(posedge clk);
        #1;
        tx_start[3] = 1'b0;
        wait_idle(3);

        // Asynchronous reset during data bit 4
        tick_div = 2;
        send(0, 8'hC3);
        wait_ticks(0, 88);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_tx", {31'd0, tx_w[0]}, 32'd1);
        chk("async_busy", {31'd0, busy_w[0]}, 32'd0);
        chk("async_done", {31'd0, done_w[0]}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        send(0, 8'h5A);
        wait_idle(0);

        repeat (20) @(posedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
